parking_gate_ctrl: RTL and testbench

Entry/exit barrier controller that produces the car-event interface consumed by the parking occupancy counter. Both lanes run the same sequence: debounce the lane's loop sensor, decide admission, open the barrier, track the car through the pass beam, then close the barrier. Each completed passage becomes one single-cycle event pulse with a university/general class flag: `car_entered`/`is_uni_car_entered` or `car_exited`/`is_uni_car_exited`. Entry admission depends on the counter's vacancy flags fed back into this block.

---
 rtl/parking_pkg.sv | 25 ++
 rtl/gate_lane.sv | 153 +++++++++++++++
 rtl/parking_gate_ctrl.sv | 91 +++++++++
 tb/tb_parking_gate_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared lane state type, default timing constants and counter sizing for the
// parking barrier controller.
package parking_pkg;

  typedef enum logic [2:0] {
    LANE_IDLE,
    LANE_QUAL,
    LANE_OPEN,
    LANE_PASSING,
    LANE_HOLD
  } lane_state_e;

  localparam int DEF_DEBOUNCE   = 4;
  localparam int DEF_CLOSE_HOLD = 8;
  localparam int DEF_TIMEOUT    = 64;

  function automatic int cntWidth(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/gate_lane.sv
// One barrier lane: input synchronizers, loop debounce, admission, passage
// tracking and close hold. PARK_GATE_TIMEOUT_EN adds an OPEN-state timeout.
module gate_lane
  import parking_pkg::*;
#(
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int CLOSE_HOLD = DEF_CLOSE_HOLD,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic loop_i,
  input  logic uni_i,
  input  logic pass_i,
  input  logic admit_i,
  output logic uni_sync_o,
  output logic gate_o,
  output logic event_o,
  output logic event_uni_o,
  output logic deny_o,
  output logic timeout_o
);

  localparam int W = cntWidth(DEBOUNCE, CLOSE_HOLD, TIMEOUT);

  logic [2:0]  meta_q;
  logic [2:0]  sync_q;
  logic        passDly_q;
  logic        loopS;
  lane_state_e state_q;
  logic [W-1:0] cnt_q;
  logic        uniLatch_q;
  logic        gate_q;
  logic        event_q;
  logic        eventUni_q;
  logic        deny_q;

  assign loopS      = sync_q[0];
  assign uni_sync_o = sync_q[2];

  // The pass beam gets one extra stage so a passage event lands three cycles
  // after the raw beam clears, while loop decisions use the plain sync.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q    <= '0;
      sync_q    <= '0;
      passDly_q <= 1'b0;
    end else begin
      meta_q    <= {uni_i, pass_i, loop_i};
      sync_q    <= meta_q;
      passDly_q <= sync_q[1];
    end
  end

`ifdef PARK_GATE_TIMEOUT_EN
  logic [W-1:0] timer_q;
  logic         timeout_q;
  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= LANE_IDLE;
      cnt_q      <= '0;
      uniLatch_q <= 1'b0;
      gate_q     <= 1'b0;
      event_q    <= 1'b0;
      eventUni_q <= 1'b0;
      deny_q     <= 1'b0;
`ifdef PARK_GATE_TIMEOUT_EN
      timer_q    <= '0;
      timeout_q  <= 1'b0;
`endif
    end else begin
      event_q    <= 1'b0;
      eventUni_q <= 1'b0;
      deny_q     <= 1'b0;
`ifdef PARK_GATE_TIMEOUT_EN
      timeout_q  <= 1'b0;
`endif
      case (state_q)
        LANE_IDLE: begin
          if (loopS) begin
            state_q <= LANE_QUAL;
            cnt_q   <= '0;
          end
        end
        LANE_QUAL: begin
          if (!loopS) begin
            state_q <= LANE_IDLE;
          end else if (cnt_q == W'(DEBOUNCE - 1)) begin
            uniLatch_q <= sync_q[2];
            if (admit_i) begin
              state_q <= LANE_OPEN;
              gate_q  <= 1'b1;
`ifdef PARK_GATE_TIMEOUT_EN
              timer_q <= '0;
`endif
            end else begin
              deny_q  <= 1'b1;
              state_q <= LANE_HOLD;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + W'(1);
          end
        end
        LANE_OPEN: begin
          if (passDly_q) begin
            state_q <= LANE_PASSING;
          end
`ifdef PARK_GATE_TIMEOUT_EN
          else if (timer_q == W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            gate_q    <= 1'b0;
            state_q   <= LANE_HOLD;
            cnt_q     <= '0;
          end else begin
            timer_q <= timer_q + W'(1);
          end
`endif
        end
        LANE_PASSING: begin
          if (!passDly_q) begin
            event_q    <= 1'b1;
            eventUni_q <= uniLatch_q;
            gate_q     <= 1'b0;
            state_q    <= LANE_HOLD;
            cnt_q      <= '0;
          end
        end
        LANE_HOLD: begin
          // A car still sitting on the loop keeps the lane parked here, so a
          // refused car cannot be refused again until it leaves and returns.
          if (cnt_q == W'(CLOSE_HOLD)) begin
            if (!loopS) state_q <= LANE_IDLE;
          end else begin
            cnt_q <= cnt_q + W'(1);
          end
        end
        default: state_q <= LANE_IDLE;
      endcase
    end
  end

  assign gate_o      = gate_q;
  assign event_o     = event_q;
  assign event_uni_o = eventUni_q;
  assign deny_o      = deny_q;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit barrier controller feeding the occupancy counter with car events.
// Define PARK_GATE_TIMEOUT_EN to abort barriers left open with no car passing.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE   = DEF_DEBOUNCE,
  parameter int CLOSE_HOLD = DEF_CLOSE_HOLD,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic entry_loop,
  input  logic exit_loop,
  input  logic entry_uni,
  input  logic exit_uni,
  input  logic entry_pass,
  input  logic exit_pass,
  input  logic uni_is_vacated_space,
  input  logic is_vacated_space,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_denied,
  output logic entry_timeout,
  output logic exit_timeout
);

  logic [2:0] ctrlMeta_q;
  logic [2:0] ctrlSync_q;
  logic       entryUni;
  logic       entryAdmit;
  logic       exitUniUnused;
  logic       exitDenyUnused;

  // Enable and the vacancy flags come from other logic, so they are
  // synchronized here before feeding the entry admission decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrlMeta_q <= '0;
      ctrlSync_q <= '0;
    end else begin
      ctrlMeta_q <= {enable, uni_is_vacated_space, is_vacated_space};
      ctrlSync_q <= ctrlMeta_q;
    end
  end

  assign entryAdmit = ctrlSync_q[2] & (entryUni ? ctrlSync_q[1] : ctrlSync_q[0]);

  gate_lane #(
    .DEBOUNCE  (DEBOUNCE),
    .CLOSE_HOLD(CLOSE_HOLD),
    .TIMEOUT   (TIMEOUT)
  ) uEntry (
    .clk_i      (clk),
    .rst_i      (reset),
    .loop_i     (entry_loop),
    .uni_i      (entry_uni),
    .pass_i     (entry_pass),
    .admit_i    (entryAdmit),
    .uni_sync_o (entryUni),
    .gate_o     (entry_gate_open),
    .event_o    (car_entered),
    .event_uni_o(is_uni_car_entered),
    .deny_o     (entry_denied),
    .timeout_o  (entry_timeout)
  );

  gate_lane #(
    .DEBOUNCE  (DEBOUNCE),
    .CLOSE_HOLD(CLOSE_HOLD),
    .TIMEOUT   (TIMEOUT)
  ) uExit (
    .clk_i      (clk),
    .rst_i      (reset),
    .loop_i     (exit_loop),
    .uni_i      (exit_uni),
    .pass_i     (exit_pass),
    .admit_i    (1'b1),
    .uni_sync_o (exitUniUnused),
    .gate_o     (exit_gate_open),
    .event_o    (car_exited),
    .event_uni_o(is_uni_car_exited),
    .deny_o     (exitDenyUnused),
    .timeout_o  (exit_timeout)
  );

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Self-checking bench for parking_gate_ctrl: directed and randomized lane
// schedules compared against a timing-rule model of both lanes.
module tb_parking_gate_ctrl;

  localparam int DEBOUNCE  = 4;
  localparam int TIMEOUT   = 64;
  localparam int GATE_LAT  = DEBOUNCE + 2;
  localparam int EVENT_LAT = 3;

  logic clk = 1'b0;
  logic reset;
  logic enable, entry_loop, exit_loop, entry_uni, exit_uni, entry_pass, exit_pass;
  logic uni_is_vacated_space, is_vacated_space;
  logic entry_gate_open, exit_gate_open, car_entered, is_uni_car_entered;
  logic car_exited, is_uni_car_exited, entry_denied, entry_timeout, exit_timeout;
  logic [8:0] obsVec;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .entry_loop          (entry_loop),
    .exit_loop           (exit_loop),
    .entry_uni           (entry_uni),
    .exit_uni            (exit_uni),
    .entry_pass          (entry_pass),
    .exit_pass           (exit_pass),
    .uni_is_vacated_space(uni_is_vacated_space),
    .is_vacated_space    (is_vacated_space),
    .entry_gate_open     (entry_gate_open),
    .exit_gate_open      (exit_gate_open),
    .car_entered         (car_entered),
    .is_uni_car_entered  (is_uni_car_entered),
    .car_exited          (car_exited),
    .is_uni_car_exited   (is_uni_car_exited),
    .entry_denied        (entry_denied),
    .entry_timeout       (entry_timeout),
    .exit_timeout        (exit_timeout)
  );

  assign obsVec = {entry_gate_open, car_entered, is_uni_car_entered, entry_denied, entry_timeout,
                   exit_gate_open, car_exited, is_uni_car_exited, exit_timeout};

  function automatic bit inWin(input int k, input int a, input int b);
    return (a >= 0) && (k >= a) && (k < b);
  endfunction

  // Expected {gate, event, eventUni, deny, timeout} for one lane at step k.
  // Steps count edges from the first edge that samples the raw loop high.
  function automatic logic [4:0] laneModel(input bit isEntry, input int k, input int la,
                                           input int lb, input int pa, input int pb,
                                           input bit uni, input bit admitted);
    logic [4:0] r;
    int openAt;
    r = '0;
    if (la < 0 || lb <= la + DEBOUNCE) return r;
    openAt = la + GATE_LAT;
    if (!admitted) begin
      if (isEntry && k == openAt) r[1] = 1'b1;
      return r;
    end
    if (pa >= 0) begin
      if (k >= openAt && k < pb + EVENT_LAT) r[4] = 1'b1;
      if (k == pb + EVENT_LAT) begin
        r[3] = 1'b1;
        r[2] = uni;
      end
    end else begin
`ifdef PARK_GATE_TIMEOUT_EN
      if (k >= openAt && k < openAt + TIMEOUT) r[4] = 1'b1;
      if (k == openAt + TIMEOUT) r[0] = 1'b1;
`else
      if (k >= openAt) r[4] = 1'b1;
`endif
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] observed, input logic [8:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Drives both lanes from loop/pass windows for n steps and checks every step.
  task automatic applyStimulus(input string tag, input int n,
                               input int eLa, input int eLb, input int ePa, input int ePb, input bit eUni,
                               input int xLa, input int xLb, input int xPa, input int xPb, input bit xUni,
                               input bit en, input bit uniVac, input bit vac);
    bit eAdm;
    logic [4:0] eExp, xExp;
    eAdm = en && (eUni ? uniVac : vac);
    enable = en;
    uni_is_vacated_space = uniVac;
    is_vacated_space = vac;
    for (int k = 0; k < n; k++) begin
      entry_loop = inWin(k, eLa, eLb);
      entry_uni  = entry_loop & eUni;
      entry_pass = inWin(k, ePa, ePb);
      exit_loop  = inWin(k, xLa, xLb);
      exit_uni   = exit_loop & xUni;
      exit_pass  = inWin(k, xPa, xPb);
      @(posedge clk);
      @(negedge clk);
      eExp = laneModel(1'b1, k, eLa, eLb, ePa, ePb, eUni, eAdm);
      xExp = laneModel(1'b0, k, xLa, xLb, xPa, xPb, xUni, 1'b1);
      checkOutput($sformatf("%s step %0d", tag, k), obsVec, {eExp, xExp[4:2], xExp[0]});
    end
  endtask

  initial begin
    int eLa, eLb, ePa, ePb, xLa, xLb, xPa, xPb, n;
    bit eUni, xUni, en, uniVac, vac;

    reset = 1'b0;
    enable = 1'b0;
    entry_loop = 1'b0; exit_loop = 1'b0;
    entry_uni = 1'b0;  exit_uni = 1'b0;
    entry_pass = 1'b0; exit_pass = 1'b0;
    uni_is_vacated_space = 1'b0; is_vacated_space = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset state", obsVec, 9'b0);
    reset = 1'b0;

    applyStimulus("general entry", 32, 0, 20, 10, 13, 1'b0, -1, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("uni denied", 67, 0, 47, -1, -1, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus("loop glitch", 12, 0, 3, -1, -1, 1'b0, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("uni entry", 30, 0, 15, 8, 10, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0);
    applyStimulus("same-cycle events", 33, 0, 16, 10, 14, 1'b0, 2, 18, 9, 14, 1'b1, 1'b1, 1'b0, 1'b1);
    applyStimulus("exit while closed", 30, -1, -1, -1, -1, 1'b0, 1, 14, 7, 9, 1'b0, 1'b0, 1'b0, 1'b0);

    applyStimulus("both open", 12, 0, 100, -1, -1, 1'b0, 0, 100, -1, -1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1 checkOutput("reset mid-open", obsVec, 9'b0);
    @(negedge clk);
    entry_loop = 1'b0; exit_loop = 1'b0; entry_uni = 1'b0; exit_uni = 1'b0;
    reset = 1'b0;
    applyStimulus("idle after reset", 10, -1, -1, -1, -1, 1'b0, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus("car after reset", 30, 1, 14, 7, 11, 1'b0, 0, 12, 6, 8, 1'b0, 1'b1, 1'b1, 1'b1);

    for (int it = 0; it < 12; it++) begin
      eUni = 1'($urandom_range(0, 1));
      xUni = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 3) != 0);
      uniVac = 1'($urandom_range(0, 1));
      vac = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) begin
        eLa = $urandom_range(0, 3);
        ePa = eLa + 4 + $urandom_range(0, 4);
        ePb = ePa + $urandom_range(1, 5);
        eLb = ePb + $urandom_range(0, 6);
      end else begin
        eLa = -1; eLb = -1; ePa = -1; ePb = -1;
      end
      if ($urandom_range(0, 3) != 0) begin
        xLa = $urandom_range(0, 3);
        xPa = xLa + 4 + $urandom_range(0, 4);
        xPb = xPa + $urandom_range(1, 5);
        xLb = xPb + $urandom_range(0, 6);
      end else begin
        xLa = -1; xLb = -1; xPa = -1; xPb = -1;
      end
      n = ((ePb > xPb) ? ePb : xPb) + 16;
      if (n < 20) n = 20;
      applyStimulus($sformatf("random %0d", it), n, eLa, eLb, ePa, ePb, eUni,
                    xLa, xLb, xPa, xPb, xUni, en, uniVac, vac);
    end

`ifdef PARK_GATE_TIMEOUT_EN
    applyStimulus("open timeout", 90, 0, 10, -1, -1, 1'b0, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b1);
`else
    applyStimulus("open no timeout", 206, 0, 10, -1, -1, 1'b0, -1, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b1);
`endif
    #2 reset = 1'b1;
    #1 checkOutput("final reset", obsVec, 9'b0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
